// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// Default widths, NOP encoding, PC step and misalignment test.
package fetch_stage_pkg;

  localparam int ADDR_W_D = 32;
  localparam int DATA_W_D = 32;
  localparam logic [31:0] NOP = 32'h0;
  localparam int PC_STEP = 4;

  function automatic logic fn_misalign(
    input logic [1:0] i_lsb
  );
    return i_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-to-decode valid/ready bundle.
// master: IfValid/IfInstr/IfPC/IfMisalign out, IfReady in.
interface fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              IfValid;
  logic              IfReady;
  logic [DATA_W-1:0] IfInstr;
  logic [ADDR_W-1:0] IfPC;
  logic              IfMisalign;

  modport master (
    output IfValid,
    output IfInstr,
    output IfPC,
    output IfMisalign,
    input  IfReady
  );

  modport slave (
    input  IfValid,
    input  IfInstr,
    input  IfPC,
    input  IfMisalign,
    output IfReady
  );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Skid buffer of fetched {misalign, pc, instr} entries.
// Ports: clk/rst_n, push/data, pop, flush -> head data, full, empty, count.
module fetch_skid_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [W-1:0]  o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop;

  function automatic logic [PW-1:0] fn_inc(
    input logic [PW-1:0] i_p
  );
    return (i_p == PW'(DEPTH - 1)) ? '0 : i_p + 1'b1;
  endfunction

  assign o_count = r_count;
  assign o_empty = r_count == '0;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= fn_inc(r_wr);
      end
      if (w_pop) begin
        r_rd <= fn_inc(r_rd);
      end
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: next-PC mux, 1-cycle imem issue, skid buffer to decode.
// Ports: Clk/Reset, PCResult->Address, Imem*, Redirect*, dec (master).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int BUF_DEPTH = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PCResult,
  output logic [ADDR_W-1:0] Address,
  output logic              ImemEn,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic [DATA_W-1:0] ImemRdata,
  input  logic              RedirectValid,
  input  logic [ADDR_W-1:0] RedirectTarget,
  fetch_stage_if.master     dec
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int EW = 1 + ADDR_W + DATA_W;

  logic              r_inflight;
  logic [ADDR_W-1:0] r_tag;

  logic [CW-1:0]     w_count;
  logic [CW:0]       w_occ;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_kill;
  logic              w_issue;
  logic              w_mis;
  logic [DATA_W-1:0] w_instr;
  logic [EW-1:0]     w_wdata;
  logic [EW-1:0]     w_head;

  assign w_kill = RedirectValid;
  assign w_pop  = dec.IfValid && dec.IfReady;

  // Occupancy after this edge: buffered + in flight, minus the entry
  // decode takes now. Counting the pop keeps one issue per cycle.
  assign w_occ = {1'b0, w_count}
               + (CW+1)'(r_inflight)
               - (CW+1)'(w_pop);

  assign w_issue = Reset && !w_kill
                && (w_occ < (CW+1)'(BUF_DEPTH));

  always_comb begin
    Address = PCResult;
    ImemEn  = 1'b0;
    unique case (1'b1)
      w_kill: begin
        Address = RedirectTarget;
      end
      w_issue: begin
        Address = PCResult + ADDR_W'(PC_STEP);
        ImemEn  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ImemAddr = PCResult;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_inflight <= 1'b0;
      r_tag      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag <= PCResult;
      end
    end
  end

  // A redirect kills the read returning this cycle.
  assign w_push  = r_inflight && !w_kill;
  assign w_mis   = fn_misalign(r_tag[1:0]);
  assign w_instr = w_mis ? DATA_W'(NOP) : ImemRdata;
  assign w_wdata = {w_mis, r_tag, w_instr};

  fetch_skid_fifo #(
    .W     (EW),
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Reset),
    .i_push  (w_push),
    .i_data  (w_wdata),
    .i_pop   (w_pop),
    .i_flush (w_kill),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign dec.IfValid = !w_empty;
  assign {dec.IfMisalign, dec.IfPC, dec.IfInstr} =
    w_empty ? '0 : w_head;

  a_no_ovf: assert property (
    @(posedge Clk) disable iff (!Reset)
    !(w_push && w_full)
  );

endmodule
